// File: rtl/snn_aer_pkg.sv
// snn_aer_pkg: shared types and constants for the AER input arbiter
// Holds the handshake FSM state enum, the default AER address width and the
// requester IDs used to record which slot was granted.
package snn_aer_pkg;
  localparam int AER_WIDTH_DEF = 10;
  localparam logic REQ_ENC = 1'b0;
  localparam logic REQ_HOST = 1'b1;
  typedef enum logic [1:0] {IDLE, REQ_HI, WAIT_LO} aer_state_t;
endpackage

// File: rtl/aer_ack_sync.sv
// aer_ack_sync: two-flop synchronizer bringing the asynchronous AER ACK into CLK
// Ports: CLK, RST (sync, active high), ACK (async in), ACK_S (synchronized out).
module aer_ack_sync (
  input  logic CLK,
  input  logic RST,
  input  logic ACK,
  output logic ACK_S
);
  logic meta;
  always_ff @(posedge CLK)
    if (RST) {ACK_S, meta} <= 2'b00;
    else {ACK_S, meta} <= {meta, ACK};
endmodule

// File: rtl/aer_in_arbiter.sv
// aer_in_arbiter: two-slot round-robin arbiter driving a 4-phase AER handshake
// Ports: CLK/RST (sync, active high); ENC_* and HOST_* are the two requesters
// (ADDR/VALID in, BUSY out = slot pending); AER_ADDR/AER_REQ/AER_ACK form the
// 4-phase link to the SNN core; TIMEOUT_ERR is sticky, cleared by ERR_CLR;
// GRANT_HOST shows the current or most recent grant.
module aer_in_arbiter
  import snn_aer_pkg::*;
#(
  parameter int AER_WIDTH = AER_WIDTH_DEF,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [AER_WIDTH-1:0] ENC_ADDR,
  input  logic                 ENC_VALID,
  output logic                 ENC_BUSY,
  input  logic [AER_WIDTH-1:0] HOST_ADDR,
  input  logic                 HOST_VALID,
  output logic                 HOST_BUSY,
  output logic [AER_WIDTH-1:0] AER_ADDR,
  output logic                 AER_REQ,
  input  logic                 AER_ACK,
  input  logic                 ERR_CLR,
  output logic                 TIMEOUT_ERR,
  output logic                 GRANT_HOST
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  aer_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic grant, ack_s, enc_pend, host_pend, sel_host, load, done, tmo, tmo_hit;
  logic [AER_WIDTH-1:0] enc_addr, host_addr;
  aer_ack_sync u_sync (.CLK(CLK), .RST(RST), .ACK(AER_ACK), .ACK_S(ack_s));
  assign ENC_BUSY = enc_pend;
  assign HOST_BUSY = host_pend;
  assign GRANT_HOST = grant == REQ_HOST;
  // host wins only if the encoder is idle or the encoder had the last grant
  assign sel_host = host_pend & (~enc_pend | grant == REQ_ENC);
  // a state lasts at most ACK_TIMEOUT cycles: give up on its last cycle
  assign tmo_hit = cnt == CW'(ACK_TIMEOUT - 1);
  assign cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    load = 1'b0;
    done = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: if (enc_pend | host_pend) begin
        state_n = REQ_HI;
        load = 1'b1;
      end
      REQ_HI: if (ack_s) state_n = WAIT_LO;
        else if (tmo_hit) begin
          state_n = IDLE;
          tmo = 1'b1;
        end
      WAIT_LO: if (!ack_s) begin
          state_n = IDLE;
          done = 1'b1;
        end else if (tmo_hit) begin
          state_n = IDLE;
          tmo = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      grant <= REQ_HOST;
      AER_ADDR <= '0;
      AER_REQ <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      enc_pend <= 1'b0;
      host_pend <= 1'b0;
      enc_addr <= '0;
      host_addr <= '0;
    end else begin
      AER_REQ <= state_n == REQ_HI;
      if (load) begin
        grant <= sel_host ? REQ_HOST : REQ_ENC;
        AER_ADDR <= sel_host ? host_addr : enc_addr;
      end
      TIMEOUT_ERR <= tmo | (TIMEOUT_ERR & ~ERR_CLR);
      // a pending slot only changes by being released; an empty one only by capture
      enc_pend <= enc_pend ? ~((done | tmo) & grant == REQ_ENC) : ENC_VALID;
      host_pend <= host_pend ? ~((done | tmo) & grant == REQ_HOST) : HOST_VALID;
      if (ENC_VALID & ~enc_pend) enc_addr <= ENC_ADDR;
      if (HOST_VALID & ~host_pend) host_addr <= HOST_ADDR;
    end
endmodule

// File: tb/tb_aer_in_arbiter.sv
// tb_aer_in_arbiter: self-checking bench for aer_in_arbiter
module tb_aer_in_arbiter;
  localparam int W = 10;
  logic clk = 1'b0, rst = 1'b1;
  logic [W-1:0] enc_addr = '0, host_addr = '0, aer_addr;
  logic enc_valid = 1'b0, host_valid = 1'b0, enc_busy, host_busy;
  logic aer_req, aer_ack, err_clr = 1'b0, timeout_err, grant_host;
  logic resp_en = 1'b0, resp_rand = 1'b0, ack_resp = 1'b0, ack_man = 1'b0;
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign aer_ack = resp_en ? ack_resp : ack_man;

  aer_in_arbiter #(.AER_WIDTH(W), .ACK_TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst),
    .ENC_ADDR(enc_addr), .ENC_VALID(enc_valid), .ENC_BUSY(enc_busy),
    .HOST_ADDR(host_addr), .HOST_VALID(host_valid), .HOST_BUSY(host_busy),
    .AER_ADDR(aer_addr), .AER_REQ(aer_req), .AER_ACK(aer_ack),
    .ERR_CLR(err_clr), .TIMEOUT_ERR(timeout_err), .GRANT_HOST(grant_host)
  );

  // Core-side responder: raises ACK d negedges after it sees REQ, drops it
  // d' negedges after REQ falls (d = 3, or random 1..6 in stream mode).
  initial begin : responder
    int d, n;
    forever begin
      @(negedge clk);
      if (resp_en && aer_req && !ack_resp) begin
        d = resp_rand ? int'($urandom_range(1, 6)) : 3;
        repeat (d - 1) @(negedge clk);
        ack_resp = 1'b1;
        n = 0;
        while (aer_req && n < 1000) begin
          @(negedge clk);
          n++;
        end
        d = resp_rand ? int'($urandom_range(1, 6)) : 3;
        repeat (d - 1) @(negedge clk);
        ack_resp = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    enc_valid = 1'b0;
    host_valid = 1'b0;
    err_clr = 1'b0;
    resp_en = 1'b0;
    ack_man = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enc_valid = 1'b0;
    host_valid = 1'b0;
    ack_man = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (aer_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", aer_req); end
    total++; if (aer_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h exp=000", aer_addr); end
    total++; if ({enc_busy, host_busy} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", {enc_busy, host_busy}); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
    total++; if (grant_host !== 1'b1) begin bad++; $display("FAIL reset_grant_host got=%b exp=1", grant_host); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int hi, n;
    logic stable;
    resp_en = 1'b1;
    resp_rand = 1'b0;
    enc_addr = 10'h1FF;
    enc_valid = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    total++; if ({enc_busy, aer_req} !== 2'b10) begin bad++; $display("FAIL single_cycle1 busy,req got=%b exp=10", {enc_busy, aer_req}); end
    @(negedge clk);
    total++; if (aer_req !== 1'b1) begin bad++; $display("FAIL single_req_cycle2 got=%b exp=1", aer_req); end
    total++; if (aer_addr !== 10'h1FF) begin bad++; $display("FAIL single_addr got=%h exp=1ff", aer_addr); end
    total++; if (grant_host !== 1'b0) begin bad++; $display("FAIL single_grant got=%b exp=0", grant_host); end
    hi = 0;
    stable = 1'b1;
    while (aer_req && hi < 50) begin
      if (aer_addr !== 10'h1FF) stable = 1'b0;
      hi++;
      @(negedge clk);
    end
    // ACK rises 2.5 cycles after REQ, then two synchronizer stages
    total++; if (hi != 5) begin bad++; $display("FAIL single_req_len got=%0d exp=5", hi); end
    n = 0;
    while (enc_busy && n < 50) begin
      if (aer_addr !== 10'h1FF) stable = 1'b0;
      @(negedge clk);
      n++;
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL single_addr_stable got=%b exp=1", stable); end
    total++; if ({enc_busy, aer_ack} !== 2'b00) begin bad++; $display("FAIL single_busy_after_ack busy,ack got=%b exp=00", {enc_busy, aer_ack}); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_tie();
    logic [W-1:0] ga[4];
    logic gh[4];
    int k, n;
    logic prev;
    do_reset();
    resp_en = 1'b1;
    resp_rand = 1'b0;
    enc_addr = 10'h005;
    host_addr = 10'h2AA;
    enc_valid = 1'b1;
    host_valid = 1'b1;
    k = 0;
    n = 0;
    prev = aer_req;
    @(negedge clk);
    enc_valid = 1'b0;
    host_valid = 1'b0;
    while (n < 200 && !(k >= 2 && !enc_busy && !host_busy)) begin
      if (aer_req && !prev && k < 4) begin
        ga[k] = aer_addr;
        gh[k] = grant_host;
        k++;
      end
      prev = aer_req;
      @(negedge clk);
      n++;
    end
    total++; if (k != 2) begin bad++; $display("FAIL tie_count got=%0d exp=2", k); end
    if (k >= 2) begin
      total++; if ({ga[0], gh[0]} !== {10'h005, 1'b0}) begin bad++; $display("FAIL tie_first addr,host got=%h,%b exp=005,0", ga[0], gh[0]); end
      total++; if ({ga[1], gh[1]} !== {10'h2AA, 1'b1}) begin bad++; $display("FAIL tie_second addr,host got=%h,%b exp=2aa,1", ga[1], gh[1]); end
    end
  endtask

  task automatic test_drop_busy();
    int rises;
    logic [W-1:0] seen;
    logic prev;
    resp_en = 1'b1;
    enc_addr = 10'h010;
    enc_valid = 1'b1;
    @(negedge clk);
    total++; if (enc_busy !== 1'b1) begin bad++; $display("FAIL drop_busy_pre got=%b exp=1", enc_busy); end
    enc_addr = 10'h020;
    prev = 1'b0;
    rises = 0;
    seen = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      enc_valid = 1'b0;
      if (aer_req && !prev) begin
        rises++;
        seen = aer_addr;
      end
      prev = aer_req;
    end
    total++; if (rises != 1) begin bad++; $display("FAIL drop_count got=%0d exp=1", rises); end
    total++; if (seen !== 10'h010) begin bad++; $display("FAIL drop_addr got=%h exp=010", seen); end
  endtask

  task automatic test_timeout();
    int hi, n;
    resp_en = 1'b0;
    ack_man = 1'b0;
    enc_addr = 10'h123;
    enc_valid = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    n = 0;
    while (!aer_req && n < 20) begin @(negedge clk); n++; end
    hi = 0;
    while (aer_req && hi < 50) begin hi++; @(negedge clk); end
    total++; if (hi != 8) begin bad++; $display("FAIL timeout_req_len got=%0d exp=8", hi); end
    total++; if ({timeout_err, enc_busy} !== 2'b10) begin bad++; $display("FAIL timeout_flag err,busy got=%b exp=10", {timeout_err, enc_busy}); end
    repeat (3) @(negedge clk);
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", timeout_err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clr got=%b exp=0", timeout_err); end
    err_clr = 1'b1;
    enc_addr = 10'h124;
    enc_valid = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    n = 0;
    while (!aer_req && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (aer_req && n < 50) begin @(negedge clk); n++; end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_set_wins got=%b exp=1", timeout_err); end
    @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clr_after got=%b exp=0", timeout_err); end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n, rises;
    logic [W-1:0] seen;
    logic prev;
    resp_en = 1'b0;
    ack_man = 1'b0;
    enc_addr = 10'h0AB;
    enc_valid = 1'b1;
    @(negedge clk);
    enc_valid = 1'b0;
    n = 0;
    while (!aer_req && n < 20) begin @(negedge clk); n++; end
    host_addr = 10'h155;
    host_valid = 1'b1;
    @(negedge clk);
    host_valid = 1'b0;
    ack_man = 1'b1;
    n = 0;
    while (aer_req && n < 20) begin @(negedge clk); n++; end
    total++; if ({aer_req, enc_busy, host_busy} !== 3'b011) begin bad++; $display("FAIL rstmid_pre req,enc,host got=%b exp=011", {aer_req, enc_busy, host_busy}); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({aer_req, enc_busy, host_busy, timeout_err} !== 4'b0000) begin bad++; $display("FAIL rstmid_state req,enc,host,err got=%b exp=0000", {aer_req, enc_busy, host_busy, timeout_err}); end
    rst = 1'b0;
    ack_man = 1'b0;
    repeat (4) @(negedge clk);
    resp_en = 1'b1;
    enc_addr = 10'h0CD;
    enc_valid = 1'b1;
    prev = 1'b0;
    rises = 0;
    seen = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      enc_valid = 1'b0;
      if (aer_req && !prev) begin
        rises++;
        seen = aer_addr;
      end
      prev = aer_req;
    end
    total++; if (rises != 1 || seen !== 10'h0CD) begin bad++; $display("FAIL rstmid_next rises,addr got=%0d,%h exp=1,0cd", rises, seen); end
    total++; if ({enc_busy, host_busy, timeout_err} !== 3'b000) begin bad++; $display("FAIL rstmid_end enc,host,err got=%b exp=000", {enc_busy, host_busy, timeout_err}); end
  endtask

  task automatic test_stream();
    logic [W-1:0] enc_q[$], host_q[$], exp_a;
    int enc_sent, host_sent, got, cyc;
    logic prev;
    do_reset();
    resp_en = 1'b1;
    resp_rand = 1'b1;
    enc_sent = 0;
    host_sent = 0;
    got = 0;
    cyc = 0;
    prev = 1'b0;
    while (got < 266 && cyc < 20000) begin
      enc_valid = enc_sent < 256 && $urandom_range(0, 3) != 0;
      enc_addr = W'($urandom);
      if (enc_valid && !enc_busy) begin enc_q.push_back(enc_addr); enc_sent++; end
      host_valid = host_sent < 10 && $urandom_range(0, 99) == 0;
      host_addr = W'($urandom);
      if (host_valid && !host_busy) begin host_q.push_back(host_addr); host_sent++; end
      @(negedge clk);
      cyc++;
      if (aer_req && !prev) begin
        got++;
        total++; if (aer_ack !== 1'b0) begin bad++; $display("FAIL stream_overlap ack_at_req got=%b exp=0", aer_ack); end
        if (grant_host ? host_q.size() == 0 : enc_q.size() == 0) begin
          total++; bad++; $display("FAIL stream_spurious host=%b addr got=%h exp=none", grant_host, aer_addr);
        end else begin
          exp_a = grant_host ? host_q.pop_front() : enc_q.pop_front();
          total++; if (aer_addr !== exp_a) begin bad++; $display("FAIL stream_order host=%b addr got=%h exp=%h", grant_host, aer_addr, exp_a); end
        end
      end
      prev = aer_req;
    end
    enc_valid = 1'b0;
    host_valid = 1'b0;
    total++; if (got != 266 || enc_sent != 256 || host_sent != 10) begin bad++; $display("FAIL stream_count got=%0d sent=%0d+%0d exp=266", got, enc_sent, host_sent); end
    total++; if (enc_q.size() + host_q.size() != 0) begin bad++; $display("FAIL stream_leftover got=%0d exp=0", enc_q.size() + host_q.size()); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL stream_err got=%b exp=0", timeout_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_drop_busy();
    test_timeout();
    test_reset_mid();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
